counter: RTL and testbench



---
 rtl/counter.sv | 27 ++
 tb/tb_counter.sv | 120 ++++++++++++
 2 files changed

// File: rtl/counter.sv
// Free-running WIDTH-bit up-counter, wraps modulo 2^WIDTH.
// Synchronous active-high reset loads RESET_VALUE; output comes straight from the register.
module counter #(
    parameter int unsigned WIDTH       = 8,
    parameter logic [31:0] RESET_VALUE = 32'd0
) (
    output logic [WIDTH-1:0] value,
    input  logic             clk,
    input  logic             reset
);

    localparam logic [WIDTH-1:0] ResetCount = RESET_VALUE[WIDTH-1:0];

    logic [WIDTH-1:0] count;

    // Natural WIDTH-bit overflow gives the wrap to zero with no extra cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            count <= ResetCount;
        end else begin
            count <= count + WIDTH'(1);
        end
    end

    assign value = count;

endmodule

// File: tb/tb_counter.sv
// Directed bench: default 8-bit counter plus a WIDTH=4, RESET_VALUE=5 instance on the same clock.
`timescale 1ns / 100ps
module tb_counter;

    logic       clk = 1'b0;
    logic       rst8 = 1'b1;
    logic       rst4 = 1'b1;
    logic [7:0] value8;
    logic [3:0] value4;

    logic [7:0] exp8;
    logic [3:0] exp4;
    int         tests = 0;
    int         fails = 0;

    always #1 clk = ~clk;

    counter dut8 (
        .value (value8),
        .clk   (clk),
        .reset (rst8)
    );

    counter #(
        .WIDTH       (4),
        .RESET_VALUE (32'd5)
    ) dut4 (
        .value (value4),
        .clk   (clk),
        .reset (rst4)
    );

    always @(value8) $display("[TB] t=%0t value8 = 0x%02h (%0d)", $time, value8, value8);

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One rising edge: update the models from the reset levels present at that edge, then
    // compare both instances on the following falling edge.
    task automatic step();
        logic r8, r4;
        @(posedge clk);
        r8 = rst8;
        r4 = rst4;
        @(negedge clk);
        exp8 = r8 ? 8'h00 : exp8 + 8'd1;
        exp4 = r4 ? 4'd5 : exp4 + 4'd1;
        check("seq8", {24'd0, value8}, {24'd0, exp8});
        check("seq4", {28'd0, value4}, {28'd0, exp4});
    endtask

    initial begin
        exp8 = 8'h00;
        exp4 = 4'd5;

        // Hold reset across three edges on both instances.
        for (int i = 0; i < 3; i++) begin
            step();
            check("rst8_hold", {24'd0, value8}, 32'h00);
            check("rst4_hold", {28'd0, value4}, 32'd5);
        end

        rst8 = 1'b0;
        rst4 = 1'b0;
        for (int m = 1; m <= 260; m++) begin
            step();
            if (m == 1) check("rel_1", {24'd0, value8}, 32'h01);
            if (m == 2) check("rel_2", {24'd0, value8}, 32'h02);
            if (m == 3) check("rel_3", {24'd0, value8}, 32'h03);
            if (m == 254) check("wrap_fe", {24'd0, value8}, 32'hFE);
            if (m == 255) check("wrap_ff", {24'd0, value8}, 32'hFF);
            if (m == 256) check("wrap_00", {24'd0, value8}, 32'h00);
            if (m == 257) check("wrap_01", {24'd0, value8}, 32'h01);
            if (m == 10) check("w4_15", {28'd0, value4}, 32'd15);
            if (m == 11) check("w4_0", {28'd0, value4}, 32'd0);
            if (m == 12) check("w4_1", {28'd0, value4}, 32'd1);
            if (m == 16) check("w4_period", {28'd0, value4}, 32'd5);
        end
        check("after260", {24'd0, value8}, 32'h04);

        // Reset pulse entirely between two rising edges must be ignored.
        #0.3 rst8 = 1'b1;
        #0.3 rst8 = 1'b0;
        step();
        check("short_pulse", {24'd0, value8}, 32'h05);

        for (int i = 0; i < 9; i++) step();
        check("reach_0e", {24'd0, value8}, 32'h0E);

        // Mid-count reset for three edges; the 4-bit instance keeps running.
        rst8 = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check("mid_rst", {24'd0, value8}, 32'h00);
        end
        rst8 = 1'b0;
        step();
        check("mid_rel_1", {24'd0, value8}, 32'h01);
        step();
        check("mid_rel_2", {24'd0, value8}, 32'h02);

        // Reset on the 4-bit instance lands on RESET_VALUE regardless of its count.
        rst4 = 1'b1;
        step();
        check("rst4_mid", {28'd0, value4}, 32'd5);
        rst4 = 1'b0;
        step();
        check("rst4_rel", {28'd0, value4}, 32'd6);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
